// File: rtl/uart_rx_frame_checker.sv
// rtl/uart_rx_frame_checker.sv - UART RX frame assembler with parity/stop checks and saturating error counters
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Frame_start,
    input  logic                  Bit_valid,
    input  logic                  Sampled_Bit,
    input  logic                  Parity_en,
    input  logic [1:0]            Parity_mode,
    input  logic                  Two_stop,
    input  logic                  Clr_counters,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_valid,
    output logic                  Parity_error,
    output logic                  Stop_error,
    output logic                  Busy,
    output logic [CNT_WIDTH-1:0]  Par_err_cnt,
    output logic [CNT_WIDTH-1:0]  Stop_err_cnt
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP1  = 3'd3;
    localparam logic [2:0] S_STOP2  = 3'd4;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]            state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  run_par_q, run_par_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  par_en_q, par_en_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  two_stop_q, two_stop_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q, stop_error_d;
    logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
    logic [CNT_WIDTH-1:0]  stop_cnt_q, stop_cnt_d;
    logic                  done;
    logic                  exp_par;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        run_par_d      = run_par_q;
        perr_d         = perr_q;
        serr_d         = serr_q;
        par_en_d       = par_en_q;
        par_mode_d     = par_mode_q;
        two_stop_d     = two_stop_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        parity_error_d = parity_error_q;
        stop_error_d   = stop_error_q;
        par_cnt_d      = par_cnt_q;
        stop_cnt_d     = stop_cnt_q;
        done           = 1'b0;
        exp_par        = 1'b0;

        // Frame_start restarts from any state and swallows a coincident bit
        if (Frame_start) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            run_par_d  = 1'b0;
            perr_d     = 1'b0;
            serr_d     = 1'b0;
            par_en_d   = Parity_en;
            par_mode_d = Parity_mode;
            two_stop_d = Two_stop;
        end else if (Bit_valid) begin
            case (state_q)
                S_DATA: begin
                    shift_d   = {Sampled_Bit, shift_q[DATA_WIDTH-1:1]};
                    run_par_d = run_par_q ^ Sampled_Bit;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    case (par_mode_q)
                        2'b00:   exp_par = run_par_q;
                        2'b01:   exp_par = ~run_par_q;
                        2'b10:   exp_par = 1'b1;
                        default: exp_par = 1'b0;
                    endcase
                    perr_d  = (Sampled_Bit != exp_par);
                    state_d = S_STOP1;
                end
                S_STOP1: begin
                    if (!Sampled_Bit) serr_d = 1'b1;
                    if (two_stop_q) state_d = S_STOP2;
                    else            done    = 1'b1;
                end
                S_STOP2: begin
                    if (!Sampled_Bit) serr_d = 1'b1;
                    done = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // serr_d already includes the stop bit sampled on this edge
        if (done) begin
            state_d        = S_IDLE;
            data_out_d     = shift_q;
            data_valid_d   = 1'b1;
            parity_error_d = perr_q;
            stop_error_d   = serr_d;
            if (perr_q && (par_cnt_q != '1)) par_cnt_d  = par_cnt_q + CNT_ONE;
            if (serr_d && (stop_cnt_q != '1)) stop_cnt_d = stop_cnt_q + CNT_ONE;
        end

        if (Clr_counters) begin
            par_cnt_d  = '0;
            stop_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            run_par_q      <= 1'b0;
            perr_q         <= 1'b0;
            serr_q         <= 1'b0;
            par_en_q       <= 1'b0;
            par_mode_q     <= 2'b00;
            two_stop_q     <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            par_cnt_q      <= '0;
            stop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            run_par_q      <= run_par_d;
            perr_q         <= perr_d;
            serr_q         <= serr_d;
            par_en_q       <= par_en_d;
            par_mode_q     <= par_mode_d;
            two_stop_q     <= two_stop_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            par_cnt_q      <= par_cnt_d;
            stop_cnt_q     <= stop_cnt_d;
        end
    end

    assign Data_out     = data_out_q;
    assign Data_valid   = data_valid_q;
    assign Parity_error = parity_error_q;
    assign Stop_error   = stop_error_q;
    assign Busy         = (state_q != S_IDLE);
    assign Par_err_cnt  = par_cnt_q;
    assign Stop_err_cnt = stop_cnt_q;
endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb/tb_uart_rx_frame_checker.sv - directed and randomized bench for uart_rx_frame_checker
module tb_uart_rx_frame_checker;
    localparam int DW = 8;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Frame_start = 1'b0;
    logic          Bit_valid = 1'b0;
    logic          Sampled_Bit = 1'b0;
    logic          Parity_en = 1'b0;
    logic [1:0]    Parity_mode = 2'b00;
    logic          Two_stop = 1'b0;
    logic          Clr_counters = 1'b0;
    logic [DW-1:0] Data_out;
    logic          Data_valid;
    logic          Parity_error;
    logic          Stop_error;
    logic          Busy;
    logic [CW-1:0] Par_err_cnt;
    logic [CW-1:0] Stop_err_cnt;

    int checks = 0;
    int errors = 0;

    // reference state: what the outputs should show after the last completed frame
    int     m_pcnt = 0;
    int     m_scnt = 0;
    logic   m_pe = 1'b0;
    logic   m_se = 1'b0;
    logic [DW-1:0] m_data = '0;

    uart_rx_frame_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .Frame_start(Frame_start), .Bit_valid(Bit_valid),
        .Sampled_Bit(Sampled_Bit), .Parity_en(Parity_en), .Parity_mode(Parity_mode),
        .Two_stop(Two_stop), .Clr_counters(Clr_counters), .Data_out(Data_out),
        .Data_valid(Data_valid), .Parity_error(Parity_error), .Stop_error(Stop_error),
        .Busy(Busy), .Par_err_cnt(Par_err_cnt), .Stop_err_cnt(Stop_err_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic fs, input logic bv, input logic b);
        Frame_start = fs;
        Bit_valid   = bv;
        Sampled_Bit = b;
        @(posedge CLK);
        #1;
        Frame_start  = 1'b0;
        Bit_valid    = 1'b0;
        Clr_counters = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data"}, 32'(Data_out), 32'(m_data));
        chk({tag, "_pe"}, 32'(Parity_error), 32'(m_pe));
        chk({tag, "_se"}, 32'(Stop_error), 32'(m_se));
        chk({tag, "_pcnt"}, 32'(Par_err_cnt), 32'(m_pcnt));
        chk({tag, "_scnt"}, 32'(Stop_err_cnt), 32'(m_scnt));
    endtask

    task automatic idle_check(input string tag);
        step(1'b0, 1'($urandom), 1'($urandom));
        chk({tag, "_dv_low"}, 32'(Data_valid), 32'd0);
        chk({tag, "_busy_idle"}, 32'(Busy), 32'd0);
        check_outputs(tag);
    endtask

    // Sends one full frame; ends on the cycle where Data_valid should be high.
    task automatic send_frame(input string tag, input logic [DW-1:0] data, input logic pen,
                              input logic [1:0] pm, input logic two, input logic pbit,
                              input logic s1, input logic s2, input logic clr, input logic gaps);
        logic bits[$];
        logic want;
        bits = {};
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(s1);
        if (two) bits.push_back(s2);

        Parity_en = pen; Parity_mode = pm; Two_stop = two;
        step(1'b1, 1'($urandom), 1'($urandom));
        chk({tag, "_busy_start"}, 32'(Busy), 32'd1);
        chk({tag, "_pe_hold"}, 32'(Parity_error), 32'(m_pe));
        // configuration must be ignored once the frame has started
        Parity_en = 1'($urandom); Parity_mode = 2'($urandom); Two_stop = 1'($urandom);

        for (int i = 0; i < bits.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom));
            if (i == bits.size() - 1) Clr_counters = clr;
            step(1'b0, 1'b1, bits[i]);
            if (i != bits.size() - 1) chk({tag, "_dv_early"}, 32'(Data_valid), 32'd0);
        end

        case (pm)
            2'b00:   want = ^data;
            2'b01:   want = ~^data;
            2'b10:   want = 1'b1;
            default: want = 1'b0;
        endcase
        m_data = data;
        m_pe   = pen && (pbit != want);
        m_se   = !s1 || (two && !s2);
        if (clr) begin
            m_pcnt = 0;
            m_scnt = 0;
        end else begin
            if (m_pe && m_pcnt < CNT_MAX) m_pcnt++;
            if (m_se && m_scnt < CNT_MAX) m_scnt++;
        end
        chk({tag, "_dv"}, 32'(Data_valid), 32'd1);
        chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
        check_outputs(tag);
    endtask

    initial begin
        #2;
        chk("rst_dv", 32'(Data_valid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        check_outputs("rst");
        @(posedge CLK); #1;
        RST = 1'b1;
        idle_check("idle0");

        send_frame("even_ok", 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_check("even_ok");
        send_frame("odd_bad", 8'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_check("odd_bad");
        send_frame("mark_ok", 8'hA5, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_check("mark_ok");
        send_frame("stop2_bad", 8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_check("stop2_bad");

        for (int i = 0; i < 5; i++) begin
            send_frame("sat", 8'($urandom), 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        idle_check("sat");
        send_frame("clr_win", 8'h81, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_check("clr_win");

        Parity_en = 1'b1; Parity_mode = 2'b00; Two_stop = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1, 1'($urandom));
            chk("abort_dv", 32'(Data_valid), 32'd0);
        end
        send_frame("after_abort", 8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_check("after_abort");

        Parity_en = 1'b0; Two_stop = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1);
        RST = 1'b0;
        #1;
        m_data = '0; m_pe = 1'b0; m_se = 1'b0; m_pcnt = 0; m_scnt = 0;
        chk("midrst_dv", 32'(Data_valid), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        check_outputs("midrst");
        @(posedge CLK); #1;
        RST = 1'b1;
        send_frame("after_rst", 8'hFF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_check("after_rst");

        for (int i = 0; i < 40; i++) begin
            send_frame("rand", 8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 7) == 0), 1'b1);
            // back-to-back: next Frame_start lands in the Data_valid cycle about half the time
            if ($urandom_range(0, 1) == 1) idle_check("rand");
        end
        idle_check("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
